// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port (req/gnt/rvalid) between the
// instruction-cache refill requester (instr_*) and the core data port (data_*).
// Requests are routed combinationally; up to DEPTH granted-but-unanswered
// transactions are tracked in an in-order ID FIFO that steers each rvalid back
// to the requester that issued it.
//
// Ports:
//   clk, res                     clock, synchronous active-low reset
//   instr_req/adr -> gnt/rvalid/read            instruction requester
//   data_req/adr/we/be/wdata -> gnt/rvalid/rdata data requester
//   mem_req/adr/we/be/wdata, mem_gnt/rvalid/rdata external memory port
//   outstanding                  number of unanswered transactions
//   rsp_err                      sticky: rvalid seen with nothing outstanding
module mem_port_arbiter #(
  parameter int unsigned DEPTH    = 4,  // power of 2, >= 2
  parameter int unsigned ARB_MODE = 0   // 0: round-robin, 1: data has priority
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       instr_req,
  input  logic [31:0]                instr_adr,
  output logic                       instr_gnt,
  output logic                       instr_rvalid,
  output logic [31:0]                instr_read,
  input  logic                       data_req,
  input  logic [31:0]                data_adr,
  input  logic                       data_we,
  input  logic [3:0]                 data_be,
  input  logic [31:0]                data_wdata,
  output logic                       data_gnt,
  output logic                       data_rvalid,
  output logic [31:0]                data_rdata,
  output logic                       mem_req,
  output logic [31:0]                mem_adr,
  output logic                       mem_we,
  output logic [3:0]                 mem_be,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IdInstr = 1'b0, IdData = 1'b1} id_e;

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, rptr_q;
  id_e           fifo_q [DEPTH];
  logic          lock_valid_q, lock_valid_d;
  id_e           lock_id_q, lock_id_d;
  id_e           rr_last_q;
  logic          rsp_err_q;

  logic full, lock_req, grant, push, pop;
  id_e  winner, head;

  assign full     = (count_q == CW'(DEPTH));
  assign lock_req = (lock_id_q == IdData) ? data_req : instr_req;

  always_comb begin
    winner = IdInstr;
    if (lock_valid_q && lock_req) begin
      winner = lock_id_q;
    end else if (data_req && !instr_req) begin
      winner = IdData;
    end else if (instr_req && !data_req) begin
      winner = IdInstr;
    end else if (instr_req && data_req) begin
      if (ARB_MODE == 1) winner = IdData;
      else               winner = (rr_last_q == IdData) ? IdInstr : IdData;
    end
  end

  assign mem_req = (instr_req | data_req) & ~full;

  always_comb begin
    mem_adr   = instr_adr;
    mem_we    = 1'b0;
    mem_be    = 4'b1111;
    mem_wdata = '0;
    if (winner == IdData) begin
      mem_adr   = data_adr;
      mem_we    = data_we;
      mem_be    = data_be;
      mem_wdata = data_wdata;
    end
  end

  // Grants are suppressed while held in reset so no transaction is lost.
  assign grant     = mem_req & mem_gnt & res;
  assign push      = grant;
  assign instr_gnt = grant & (winner == IdInstr);
  assign data_gnt  = grant & (winner == IdData);

  assign pop          = mem_rvalid & (count_q != '0);
  assign head         = fifo_q[rptr_q];
  assign instr_rvalid = pop & (head == IdInstr);
  assign data_rvalid  = pop & (head == IdData);
  assign instr_read   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign outstanding = count_q;
  assign rsp_err     = rsp_err_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Lock the current winner while it waits for a grant so the presented
  // address stays stable; drop it on grant or when the locked side withdraws.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    if (grant) begin
      lock_valid_d = 1'b0;
    end else if (mem_req) begin
      lock_valid_d = 1'b1;
      lock_id_d    = winner;
    end else if (!(lock_valid_q && lock_req)) begin
      lock_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= IdInstr;
      rr_last_q    <= IdData;
      rsp_err_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      if (push) begin
        fifo_q[wptr_q] <= winner;
        wptr_q         <= wptr_q + AW'(1);
        rr_last_q      <= winner;
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (mem_rvalid && (count_q == '0)) rsp_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Expected responses are queued when a
// grant is expected and popped when the bench returns rvalid on the memory side.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid;
  logic [31:0] instr_adr, data_adr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [31:0] instr_read, data_rdata, mem_adr, mem_wdata;
  logic        mem_req, mem_we, rsp_err;
  logic [3:0]  mem_be;
  logic [2:0]  outstanding;
  // Fixed-priority instance; only its grants are checked.
  logic        f_instr_gnt, f_instr_rvalid, f_data_gnt, f_data_rvalid;
  logic [31:0] f_instr_read, f_data_rdata, f_mem_adr, f_mem_wdata;
  logic        f_mem_req, f_mem_we, f_rsp_err;
  logic [3:0]  f_mem_be;
  logic [2:0]  f_outstanding;

  typedef struct {bit id; logic [31:0] data;} rsp_t;
  rsp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int seq   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DEPTH(4), .ARB_MODE(0)) dut (
    .clk(clk), .res(res),
    .instr_req(instr_req), .instr_adr(instr_adr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_read(instr_read),
    .data_req(data_req), .data_adr(data_adr), .data_we(data_we), .data_be(data_be),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .outstanding(outstanding), .rsp_err(rsp_err)
  );

  mem_port_arbiter #(.DEPTH(4), .ARB_MODE(1)) u_fixed (
    .clk(clk), .res(res),
    .instr_req(instr_req), .instr_adr(instr_adr), .instr_gnt(f_instr_gnt),
    .instr_rvalid(f_instr_rvalid), .instr_read(f_instr_read),
    .data_req(data_req), .data_adr(data_adr), .data_we(data_we), .data_be(data_be),
    .data_wdata(data_wdata), .data_gnt(f_data_gnt), .data_rvalid(f_data_rvalid),
    .data_rdata(f_data_rdata),
    .mem_req(f_mem_req), .mem_adr(f_mem_adr), .mem_we(f_mem_we), .mem_be(f_mem_be),
    .mem_wdata(f_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .outstanding(f_outstanding), .rsp_err(f_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: optionally return a memory response, then check routing and grants.
  // exp_g: -1 no grant, 0 instr, 1 data.
  task automatic cyc(input int exp_g, input bit rsp);
    rsp_t        e;
    logic [31:0] v;
    mem_rvalid = rsp;
    mem_rdata  = (rsp && exp_q.size() > 0) ? exp_q[0].data : 32'hDEAD_BEEF;
    @(negedge clk);
    if (rsp && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rvalid_i", {31'd0, instr_rvalid}, {31'd0, e.id == 1'b0});
      chk("rvalid_d", {31'd0, data_rvalid}, {31'd0, e.id == 1'b1});
      chk("rdata", e.id ? data_rdata : instr_read, e.data);
    end else begin
      chk("no_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    end
    chk("gnt_i", {31'd0, instr_gnt}, {31'd0, exp_g == 0});
    chk("gnt_d", {31'd0, data_gnt}, {31'd0, exp_g == 1});
    if (exp_g >= 0) begin
      v = 32'h0050_0093 + seq * 32'h1000;
      seq++;
      exp_q.push_back('{exp_g[0], v});
    end
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    res = 1'b0;
    cyc(-1, 1'b0);
    res = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    res = 1'b0; instr_req = 0; data_req = 0; data_we = 0; mem_gnt = 0; mem_rvalid = 0;
    instr_adr = '0; data_adr = '0; data_wdata = '0; data_be = '0; mem_rdata = '0;
    cyc(-1, 1'b0);
    // Held in reset: request path live, grants masked.
    instr_req = 1; instr_adr = 32'h80; mem_gnt = 1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd1);
    chk("rst_mem_adr", mem_adr, 32'h80);
    cyc(-1, 1'b0);
    chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    res = 1'b1;

    // Single instruction read.
    #1;
    chk("i_mem_be", {28'd0, mem_be}, 32'hF);
    chk("i_mem_we", {31'd0, mem_we}, 32'd0);
    cyc(0, 1'b0);
    instr_req = 0;
    chk("i_out1", {29'd0, outstanding}, 32'd1);
    cyc(-1, 1'b0);
    cyc(-1, 1'b1);
    chk("i_out0", {29'd0, outstanding}, 32'd0);

    // Round-robin alternation, fill to DEPTH, full back-pressure.
    pulse_reset();
    instr_req = 1; data_req = 1; data_adr = 32'h200; data_we = 0; data_be = 4'hF;
    mem_gnt = 1;
    cyc(0, 1'b0); cyc(1, 1'b0); cyc(0, 1'b0); cyc(1, 1'b0);
    chk("full_out", {29'd0, outstanding}, 32'd4);
    chk("full_mem_req", {31'd0, mem_req}, 32'd0);
    cyc(-1, 1'b0);
    cyc(-1, 1'b1);
    chk("pop_out", {29'd0, outstanding}, 32'd3);
    cyc(0, 1'b0);
    chk("refill_out", {29'd0, outstanding}, 32'd4);
    instr_req = 0; data_req = 0;
    for (int i = 0; i < 4; i++) cyc(-1, 1'b1);
    chk("drain_out", {29'd0, outstanding}, 32'd0);

    // Stalled store keeps the port locked on data.
    pulse_reset();
    mem_gnt = 0; data_req = 1; data_adr = 32'h100; data_we = 1; data_be = 4'b0011;
    data_wdata = 32'hCAFE_0123;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) instr_req = 1;
      if (c == 3) mem_gnt = 1;
      #1;
      chk("st_adr", mem_adr, 32'h100);
      chk("st_we", {31'd0, mem_we}, 32'd1);
      chk("st_be", {28'd0, mem_be}, 32'h3);
      cyc((c == 3) ? 1 : -1, 1'b0);
    end
    data_req = 0;
    #1;
    chk("st_i_adr", mem_adr, 32'h80);
    cyc(0, 1'b0);
    instr_req = 0;
    cyc(-1, 1'b1); cyc(-1, 1'b1);

    // Stray response sets the sticky error.
    cyc(-1, 1'b1);
    chk("stray_err", {31'd0, rsp_err}, 32'd1);
    cyc(-1, 1'b0);
    chk("stray_sticky", {31'd0, rsp_err}, 32'd1);

    // Reset with transactions outstanding and a lock held.
    instr_req = 1; data_req = 1; data_we = 0; mem_gnt = 1;
    cyc(1, 1'b0); cyc(0, 1'b0);
    instr_req = 0; mem_gnt = 0;
    cyc(-1, 1'b0);
    chk("pre_rst_out", {29'd0, outstanding}, 32'd2);
    data_req = 0;
    pulse_reset();
    chk("post_rst_out", {29'd0, outstanding}, 32'd0);
    chk("post_rst_err", {31'd0, rsp_err}, 32'd0);
    cyc(-1, 1'b1);
    chk("late_rsp_err", {31'd0, rsp_err}, 32'd1);
    instr_req = 1; data_req = 1; mem_gnt = 1;
    #1;
    chk("fixed_gnt_d", {31'd0, f_data_gnt}, 32'd1);
    chk("fixed_gnt_i", {31'd0, f_instr_gnt}, 32'd0);
    cyc(0, 1'b0);
    instr_req = 0; data_req = 0; mem_gnt = 0;
    cyc(-1, 1'b1);
    chk("end_out", {29'd0, outstanding}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
